// File: rtl/axis_spi_slave.sv
// axis_spi_slave
//   SPI slave (all four CPOL/CPHA modes) bridging to AXI-Stream. All SPI
//   inputs are oversampled in the clk_i domain through 2-flop synchronizers
//   (SCLK must be at most clk_i/8). Words received on MOSI are presented on
//   m_axis; words taken from s_axis are shifted out on MISO, MSB first.
//
// Parameters
//   DATA_WIDTH  bits per SPI word / AXI-Stream data width
//   CNT_WIDTH   width of the statistics counters
//
// Ports
//   clk_i, rstn_i          system clock, synchronous active-low reset
//   cpol_i, cpha_i         SPI mode, latched when chip select falls
//   sclk_i, cs_n_i, mosi_i asynchronous SPI inputs from the master
//   miso_o, miso_oe_o      slave data out and its tristate enable
//   s_axis_*               TX words to shift out on MISO
//   m_axis_*               RX words received from MOSI
//   overrun_o              one-cycle pulse when a received word is dropped
//   overrun_cnt_o          dropped RX word count
//   underrun_cnt_o         zero-filled TX word count
//
// Configuration
//   AXIS_SPI_SLAVE_STAT_EN  when defined, the two saturating statistics
//                           counters are built; otherwise both ports read 0.

module axis_spi_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overrun_o,
  output logic [CNT_WIDTH-1:0]  overrun_cnt_o,
  output logic [CNT_WIDTH-1:0]  underrun_cnt_o
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER
  } state_t;

  state_t state, state_nxt;

  // synchronizers plus one extra SCLK/CS stage for edge detection
  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;

  logic                  cpol_q, cpha_q;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [BW-1:0]         bit_cnt;
  logic                  need_load;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  overrun_q;

  logic cs_fall;
  logic sclk_rise, sclk_fall;
  logic active;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic word_done;
  logic load_en;
  logic overrun_evt;
  logic preview;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= sclk_i;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= cs_n_i;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= mosi_i;
      mosi_sync <= mosi_meta;
    end
  end

  assign cs_fall   = cs_prev & ~cs_sync;
  assign sclk_rise = ~sclk_prev & sclk_sync;
  assign sclk_fall = sclk_prev & ~sclk_sync;

  // SCLK edges count only inside a transfer with CS still low
  assign active      = (state == XFER) & ~cs_sync;
  assign lead_edge   = active & (cpol_q ? sclk_fall : sclk_rise);
  assign trail_edge  = active & (cpol_q ? sclk_rise : sclk_fall);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  // CPHA=1: the first leading edge of a word presents the MSB already in
  // place, so only leading edges after the first sample shift.
  assign shift_edge  = cpha_q ? (lead_edge & (bit_cnt != '0)) : trail_edge;
  assign word_done   = sample_edge & (bit_cnt == LAST_BIT);

  assign rx_word     = {rx_shift, mosi_sync};
  assign overrun_evt = word_done & m_valid & ~m_axis_tready;
  assign preview     = s_axis_tvalid & s_axis_tdata[DATA_WIDTH-1];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Words after the first are fetched lazily on the first leading edge of
  // the next word, so a transfer that ends on a word boundary never consumes
  // or zero-fills a word it will not send. Until then MISO previews the
  // s_axis MSB directly.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = XFER;
      end
      XFER: begin
        load_en = lead_edge & need_load;
        if (cs_sync) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if ((state == IDLE) && cs_fall) begin
      cpol_q <= cpol_i;
      cpha_q <= cpha_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      tx_shift <= '0;
    end else if (load_en) begin
      tx_shift <= s_axis_tvalid ? s_axis_tdata : '0;
    end else if (state == IDLE) begin
      tx_shift <= '0;
    end else if (shift_edge) begin
      tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      need_load <= 1'b0;
    end else if ((state != XFER) || cs_sync) begin
      need_load <= 1'b0;
    end else if (word_done) begin
      need_load <= 1'b1;
    end else if (lead_edge) begin
      need_load <= 1'b0;
    end
  end

  // partial words are simply discarded when CS leaves mid-word
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if ((state != XFER) || cs_sync) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (sample_edge) begin
      rx_shift <= rx_word[DATA_WIDTH-2:0];
      bit_cnt  <= word_done ? '0 : bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_evt;
      if (word_done && (!m_valid || m_axis_tready)) begin
        m_data  <= rx_word;
        m_valid <= 1'b1;
      end else if (m_valid && m_axis_tready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign miso_o        = ~cs_sync & (((state == LOAD) || need_load) ? preview
                                                                     : tx_shift[DATA_WIDTH-1]);
  assign miso_oe_o     = ~cs_sync;
  assign s_axis_tready = load_en & s_axis_tvalid;
  assign m_axis_tdata  = m_data;
  assign m_axis_tvalid = m_valid;
  assign overrun_o     = overrun_q;

`ifdef AXIS_SPI_SLAVE_STAT_EN
  logic                 underrun_evt;
  logic [CNT_WIDTH-1:0] ovr_cnt;
  logic [CNT_WIDTH-1:0] und_cnt;

  assign underrun_evt = load_en & ~s_axis_tvalid;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ovr_cnt <= '0;
      und_cnt <= '0;
    end else begin
      if (overrun_evt && (ovr_cnt != '1)) begin
        ovr_cnt <= ovr_cnt + CNT_WIDTH'(1);
      end
      if (underrun_evt && (und_cnt != '1)) begin
        und_cnt <= und_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign overrun_cnt_o  = ovr_cnt;
  assign underrun_cnt_o = und_cnt;
`else
  assign overrun_cnt_o  = '0;
  assign underrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axis_spi_slave.sv
// tb_axis_spi_slave
//   Directed bench for axis_spi_slave: an SPI master driven from tasks, an
//   s_axis word source fed from a table, and m_axis / pulse monitors.
//   Counter expectations follow AXIS_SPI_SLAVE_STAT_EN.

module tb_axis_spi_slave;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int H  = 40;  // SCLK half period: clk/8

`ifdef AXIS_SPI_SLAVE_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic          clk;
  logic          rstn;
  logic          cpol, cpha, sclk, cs_n, mosi;
  logic          miso_o, miso_oe_o;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready;
  logic          overrun_o;
  logic [CW-1:0] overrun_cnt_o, underrun_cnt_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] tx_mem [0:255];
  int         tx_num   = 0;
  int         tx_taken = 0;
  logic [7:0] rx_mem [0:255];
  int         rx_cnt   = 0;
  int         rdy_pulses = 0;
  int         ovr_pulses = 0;

  axis_spi_slave #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .cpol_i        (cpol),
    .cpha_i        (cpha),
    .sclk_i        (sclk),
    .cs_n_i        (cs_n),
    .mosi_i        (mosi),
    .miso_o        (miso_o),
    .miso_oe_o     (miso_oe_o),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overrun_o     (overrun_o),
    .overrun_cnt_o (overrun_cnt_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_axis_tvalid = (tx_taken < tx_num);
  assign s_axis_tdata  = tx_mem[tx_taken[7:0]];

  always @(posedge clk) begin
    if (s_axis_tvalid && s_axis_tready) tx_taken <= tx_taken + 1;
  end

  always @(negedge clk) begin
    if (s_axis_tready) rdy_pulses = rdy_pulses + 1;
    if (overrun_o) ovr_pulses = ovr_pulses + 1;
    if (m_axis_tvalid && m_axis_tready) begin
      rx_mem[rx_cnt[7:0]] = m_axis_tdata;
      rx_cnt = rx_cnt + 1;
    end
  end

  task automatic queue_tx(input logic [7:0] w);
    tx_mem[tx_num[7:0]] = w;
    tx_num = tx_num + 1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic spi_start();
    cs_n = 1'b0;
    #(2*H);
  endtask

  task automatic spi_end();
    #(H);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    #1;
  endtask

  // shifts the top nbits of w out MSB first; mb collects MISO as the
  // master would latch it
  task automatic spi_xfer(input logic [7:0] w, input int nbits, output logic [7:0] mb);
    mb = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = w[i];
        #(H);
        mb[i] = miso_o;
        sclk = ~cpol;
        #(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = w[i];
        #(H);
        mb[i] = miso_o;
        sclk = cpol;
        #(H);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %0b expected 0", m_axis_tvalid); end
    tests++; if (m_axis_tdata !== 8'h00) begin fails++; $display("FAIL reset_tdata got %0h expected 0", m_axis_tdata); end
    tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready got %0b expected 0", s_axis_tready); end
    tests++; if ({miso_o, miso_oe_o, overrun_o} !== 3'b000) begin fails++; $display("FAIL reset_miso_oe_ovr got %0b expected 000", {miso_o, miso_oe_o, overrun_o}); end
    tests++; if (overrun_cnt_o !== '0 || underrun_cnt_o !== '0) begin fails++; $display("FAIL reset_counters got %0h/%0h expected 0/0", overrun_cnt_o, underrun_cnt_o); end
    rstn = 1'b1;
    settle();
  endtask

  task automatic test_mode0_basic();
    int rx0, rdy0, ov0;
    logic [7:0] mb;
    set_mode(1'b0, 1'b0);
    m_axis_tready = 1'b1;
    rx0 = rx_cnt; rdy0 = rdy_pulses; ov0 = ovr_pulses;
    queue_tx(8'h3C);
    spi_start();
    tests++; if (miso_oe_o !== 1'b1) begin fails++; $display("FAIL basic_oe got %0b expected 1", miso_oe_o); end
    spi_xfer(8'hA5, 8, mb);
    spi_end();
    tests++; if (mb !== 8'h3C) begin fails++; $display("FAIL basic_miso got %0h expected 3c", mb); end
    tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL basic_rx_count got %0d expected 1", rx_cnt - rx0); end
    tests++; if (rx_mem[rx0[7:0]] !== 8'hA5) begin fails++; $display("FAIL basic_rx_data got %0h expected a5", rx_mem[rx0[7:0]]); end
    tests++; if (rdy_pulses - rdy0 !== 1) begin fails++; $display("FAIL basic_tready_pulses got %0d expected 1", rdy_pulses - rdy0); end
    tests++; if (ovr_pulses - ov0 !== 0) begin fails++; $display("FAIL basic_overrun got %0d expected 0", ovr_pulses - ov0); end
  endtask

  task automatic test_modes();
    int rx0, rdy0;
    logic [7:0] mb1, mb2;
    logic [1:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 2'(k);
      set_mode(m[1], m[0]);
      rx0 = rx_cnt; rdy0 = rdy_pulses;
      queue_tx(8'hC3);
      queue_tx(8'h5A);
      spi_start();
      spi_xfer(8'h81, 8, mb1);
      spi_xfer(8'h7E, 8, mb2);
      spi_end();
      tests++; if (rx_cnt - rx0 !== 2) begin fails++; $display("FAIL mode%0d_rx_count got %0d expected 2", k, rx_cnt - rx0); end
      tests++; if (rx_mem[rx0[7:0]] !== 8'h81) begin fails++; $display("FAIL mode%0d_rx_word0 got %0h expected 81", k, rx_mem[rx0[7:0]]); end
      tests++; if (rx_mem[8'(rx0 + 1)] !== 8'h7E) begin fails++; $display("FAIL mode%0d_rx_word1 got %0h expected 7e", k, rx_mem[8'(rx0 + 1)]); end
      tests++; if (rdy_pulses - rdy0 !== 2) begin fails++; $display("FAIL mode%0d_tready_pulses got %0d expected 2", k, rdy_pulses - rdy0); end
      tests++; if ({mb1, mb2} !== 16'hC35A) begin fails++; $display("FAIL mode%0d_miso got %0h expected c35a", k, {mb1, mb2}); end
    end
  endtask

  task automatic test_overrun();
    int rx0, ov0;
    logic [7:0] mb;
    set_mode(1'b0, 1'b0);
    m_axis_tready = 1'b0;
    ov0 = ovr_pulses;
    queue_tx(8'hAA);
    queue_tx(8'hBB);
    queue_tx(8'hCC);
    spi_start();
    spi_xfer(8'h11, 8, mb);
    spi_xfer(8'h22, 8, mb);
    spi_xfer(8'h33, 8, mb);
    spi_end();
    tests++; if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL ovr_tvalid_held got %0b expected 1", m_axis_tvalid); end
    tests++; if (m_axis_tdata !== 8'h11) begin fails++; $display("FAIL ovr_tdata_held got %0h expected 11", m_axis_tdata); end
    tests++; if (ovr_pulses - ov0 !== 2) begin fails++; $display("FAIL ovr_pulses got %0d expected 2", ovr_pulses - ov0); end
    tests++; if (overrun_cnt_o !== CW'(2 * STAT)) begin fails++; $display("FAIL ovr_count got %0d expected %0d", overrun_cnt_o, 2 * STAT); end
    rx0 = rx_cnt;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    settle();
    settle();
    tests++; if (rx_cnt - rx0 !== 1 || rx_mem[rx0[7:0]] !== 8'h11) begin fails++; $display("FAIL ovr_drain got %0d words first %0h expected 1 word 11", rx_cnt - rx0, rx_mem[rx0[7:0]]); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL ovr_tvalid_cleared got %0b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_underrun();
    int rx0, rdy0;
    logic [7:0] mb;
    set_mode(1'b0, 1'b0);
    m_axis_tready = 1'b1;
    rx0 = rx_cnt; rdy0 = rdy_pulses;
    spi_start();
    spi_xfer(8'h96, 8, mb);
    spi_end();
    tests++; if (mb !== 8'h00) begin fails++; $display("FAIL und_miso got %0h expected 0", mb); end
    tests++; if (rdy_pulses - rdy0 !== 0) begin fails++; $display("FAIL und_tready got %0d expected 0", rdy_pulses - rdy0); end
    tests++; if (underrun_cnt_o !== CW'(STAT)) begin fails++; $display("FAIL und_count got %0d expected %0d", underrun_cnt_o, STAT); end
    tests++; if (rx_cnt - rx0 !== 1 || rx_mem[rx0[7:0]] !== 8'h96) begin fails++; $display("FAIL und_rx got %0d words first %0h expected 1 word 96", rx_cnt - rx0, rx_mem[rx0[7:0]]); end
  endtask

  task automatic test_cs_abort();
    int rx0, ov0;
    logic [7:0] mb;
    set_mode(1'b0, 1'b0);
    m_axis_tready = 1'b1;
    rx0 = rx_cnt; ov0 = ovr_pulses;
    queue_tx(8'h01);
    queue_tx(8'h02);
    spi_start();
    spi_xfer(8'hFF, 5, mb);
    spi_end();
    tests++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL abort_partial got %0d words expected 0", rx_cnt - rx0); end
    spi_start();
    spi_xfer(8'hF0, 8, mb);
    spi_end();
    tests++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL abort_rx_count got %0d expected 1", rx_cnt - rx0); end
    tests++; if (rx_mem[rx0[7:0]] !== 8'hF0) begin fails++; $display("FAIL abort_rx_data got %0h expected f0", rx_mem[rx0[7:0]]); end
    tests++; if (ovr_pulses - ov0 !== 0) begin fails++; $display("FAIL abort_overrun got %0d expected 0", ovr_pulses - ov0); end
  endtask

  task automatic test_reset_mid();
    int rx0;
    logic [7:0] mb;
    set_mode(1'b0, 1'b0);
    m_axis_tready = 1'b0;
    queue_tx(8'h99);
    spi_start();
    spi_xfer(8'h66, 8, mb);
    spi_end();
    tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h66) begin fails++; $display("FAIL rstmid_pending got %0b/%0h expected 1/66", m_axis_tvalid, m_axis_tdata); end
    queue_tx(8'h77);
    spi_start();
    spi_xfer(8'hC3, 4, mb);
    @(negedge clk);
    rstn = 1'b0;
    settle();
    tests++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00) begin fails++; $display("FAIL rstmid_maxis got %0b/%0h expected 0/0", m_axis_tvalid, m_axis_tdata); end
    tests++; if ({miso_o, miso_oe_o, s_axis_tready, overrun_o} !== 4'b0000) begin fails++; $display("FAIL rstmid_outputs got %0b expected 0000", {miso_o, miso_oe_o, s_axis_tready, overrun_o}); end
    tests++; if (overrun_cnt_o !== '0 || underrun_cnt_o !== '0) begin fails++; $display("FAIL rstmid_counters got %0h/%0h expected 0/0", overrun_cnt_o, underrun_cnt_o); end
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    m_axis_tready = 1'b1;
    rx0 = rx_cnt;
    queue_tx(8'h24);
    spi_start();
    spi_xfer(8'h5A, 8, mb);
    spi_end();
    tests++; if (rx_cnt - rx0 !== 1 || rx_mem[rx0[7:0]] !== 8'h5A) begin fails++; $display("FAIL rstmid_after got %0d words first %0h expected 1 word 5a", rx_cnt - rx0, rx_mem[rx0[7:0]]); end
    tests++; if (mb !== 8'h24) begin fails++; $display("FAIL rstmid_after_miso got %0h expected 24", mb); end
  endtask

  initial begin
    rstn = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_mode0_basic();
    test_modes();
    test_overrun();
    test_underrun();
    test_cs_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
